// File: rtl/inp_camera_roi_pkg.sv
// Shared defaults and helpers for the camera input stage.
// Polarity bit positions index the {dval_pol, fval_pol, lval_pol} vector.
package inp_camera_pkg;

  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_X_WIDTH     = 12;
  localparam int DEF_Y_WIDTH     = 12;
  localparam int DEF_FCNT_WIDTH  = 16;

  localparam int POL_LV = 0;
  localparam int POL_FV = 1;
  localparam int POL_DV = 2;

  function automatic int lane_lsb(input int lane, input int pixel_width);
    return lane * pixel_width;
  endfunction

endpackage

// File: rtl/inp_camera_roi_cam_edge_det.sv
// Rise/fall pulses of a level signal, compared against its registered previous value.
// Pulses are valid in the same cycle the new level is seen.
module cam_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= sig;
  end

  assign rise = sig & ~prev;
  assign fall = ~sig & prev;

endmodule

// File: rtl/inp_camera_roi.sv
// Camera input stage: stage 1 registers and normalises the pins, stage 2 tracks
// coordinates, crops to a frame-latched ROI, counts frames and flags ragged lines.
module inp_camera_roi
  import inp_camera_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int X_WIDTH     = DEF_X_WIDTH,
  parameter int Y_WIDTH     = DEF_Y_WIDTH,
  parameter int FCNT_WIDTH  = DEF_FCNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          lval_pol,
  input  logic                          fval_pol,
  input  logic                          dval_pol,
  input  logic                          lval,
  input  logic                          fval,
  input  logic                          dval,
  input  logic [NUM_CH*PIXEL_WIDTH-1:0] pix_data,
  input  logic                          roi_en,
  input  logic [X_WIDTH-1:0]            roi_x0,
  input  logic [Y_WIDTH-1:0]            roi_y0,
  input  logic [X_WIDTH-1:0]            roi_w,
  input  logic [Y_WIDTH-1:0]            roi_h,
  input  logic                          err_clr,
  output logic                          vsync,
  output logic                          hsync,
  output logic                          de,
  output logic [NUM_CH*PIXEL_WIDTH-1:0] data,
  output logic [X_WIDTH-1:0]            x,
  output logic [Y_WIDTH-1:0]            y,
  output logic                          sof,
  output logic                          eof,
  output logic [FCNT_WIDTH-1:0]         frame_cnt,
  output logic                          line_err
);

  localparam int DW = NUM_CH * PIXEL_WIDTH;

  logic [2:0] pol;
  assign pol = {dval_pol, fval_pol, lval_pol};

  // stage 1: pin registers (ROI and clear are staged too so they line up with fv/lv)
  logic               fv1, lv1, dv1, err_clr1;
  logic [DW-1:0]      data1;
  logic               roi_en1;
  logic [X_WIDTH-1:0] roi_x01, roi_w1;
  logic [Y_WIDTH-1:0] roi_y01, roi_h1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fv1      <= 1'b0;
      lv1      <= 1'b0;
      dv1      <= 1'b0;
      err_clr1 <= 1'b0;
      data1    <= '0;
      roi_en1  <= 1'b0;
      roi_x01  <= '0;
      roi_y01  <= '0;
      roi_w1   <= '0;
      roi_h1   <= '0;
    end else begin
      fv1      <= fval ^ pol[POL_FV];
      lv1      <= lval ^ pol[POL_LV];
      dv1      <= dval ^ pol[POL_DV];
      err_clr1 <= err_clr;
      data1    <= pix_data;
      roi_en1  <= roi_en;
      roi_x01  <= roi_x0;
      roi_y01  <= roi_y0;
      roi_w1   <= roi_w;
      roi_h1   <= roi_h;
    end
  end

  logic fv_rise, fv_fall, lv_rise, lv_fall;

  cam_edge_det u_fv_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (fv1),
    .rise (fv_rise),
    .fall (fv_fall)
  );

  cam_edge_det u_lv_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (lv1),
    .rise (lv_rise),
    .fall (lv_fall)
  );

  // stage 2 state
  logic               sh_en;
  logic [X_WIDTH-1:0] sh_x0, sh_w;
  logic [Y_WIDTH-1:0] sh_y0, sh_h;
  logic [X_WIDTH-1:0] x_cnt, ref_len;
  logic [Y_WIDTH-1:0] y_cnt;
  logic               first_done;

  // On the fv rise cycle the freshly staged ROI already applies to that cycle's pixel.
  logic               en_c;
  logic [X_WIDTH-1:0] x0_c, w_c;
  logic [Y_WIDTH-1:0] y0_c, h_c;
  assign en_c = fv_rise ? roi_en1 : sh_en;
  assign x0_c = fv_rise ? roi_x01 : sh_x0;
  assign w_c  = fv_rise ? roi_w1  : sh_w;
  assign y0_c = fv_rise ? roi_y01 : sh_y0;
  assign h_c  = fv_rise ? roi_h1  : sh_h;

  logic [X_WIDTH-1:0] x_cur, x_nxt;
  logic [Y_WIDTH-1:0] y_cur, y_nxt;
  logic               pix, line_close, first_c, err_set;
  logic               x_in, y_in, de_nxt;

  assign x_cur = lv_rise ? '0 : x_cnt;
  assign y_cur = fv_rise ? '0 : y_cnt;
  assign pix   = fv1 & lv1 & dv1;

  // a line only closes inside an established frame
  assign line_close = lv_fall & fv1 & ~fv_rise;
  assign first_c    = fv_rise ? 1'b0 : first_done;
  assign err_set    = line_close & first_c & (x_cur != ref_len);

  assign x_nxt = (pix && !(&x_cur)) ? x_cur + 1'b1 : x_cur;
  assign y_nxt = (line_close && !(&y_cur)) ? y_cur + 1'b1 : y_cur;

  // one extra bit so x0+w cannot wrap back into range
  assign x_in = ({1'b0, x_cur} >= {1'b0, x0_c}) &&
                ({1'b0, x_cur} <  ({1'b0, x0_c} + {1'b0, w_c}));
  assign y_in = ({1'b0, y_cur} >= {1'b0, y0_c}) &&
                ({1'b0, y_cur} <  ({1'b0, y0_c} + {1'b0, h_c}));

  assign de_nxt = pix & (~en_c | (x_in & y_in));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_en      <= 1'b0;
      sh_x0      <= '0;
      sh_w       <= '0;
      sh_y0      <= '0;
      sh_h       <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      ref_len    <= '0;
      first_done <= 1'b0;
      vsync      <= 1'b0;
      hsync      <= 1'b0;
      de         <= 1'b0;
      data       <= '0;
      x          <= '0;
      y          <= '0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
    end else begin
      sh_en      <= en_c;
      sh_x0      <= x0_c;
      sh_w       <= w_c;
      sh_y0      <= y0_c;
      sh_h       <= h_c;
      x_cnt      <= x_nxt;
      y_cnt      <= y_nxt;
      first_done <= first_c;
      if (line_close && !first_c) begin
        ref_len    <= x_cur;
        first_done <= 1'b1;
      end
      if (err_set)       line_err <= 1'b1;
      else if (err_clr1) line_err <= 1'b0;
      vsync <= fv1;
      hsync <= lv1;
      sof   <= fv_rise;
      eof   <= fv_fall;
      de    <= de_nxt;
      if (fv_fall) frame_cnt <= frame_cnt + 1'b1;
      if (de_nxt) begin
        x <= en_c ? x_cur - x0_c : x_cur;
        y <= en_c ? y_cur - y0_c : y_cur;
        for (int k = 0; k < NUM_CH; k++)
          data[lane_lsb(k, PIXEL_WIDTH) +: PIXEL_WIDTH] <= data1[lane_lsb(k, PIXEL_WIDTH) +: PIXEL_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_inp_camera_roi.sv
// Bench for inp_camera_roi: frame table plus hand sequences, pixels checked
// against a queue of expected (x, y, data, cycle) entries.
module tb_inp_camera_roi;

  localparam int PW = 8;
  localparam int NC = 2;
  localparam int XW = 12;
  localparam int YW = 12;
  localparam int FW = 4;

  logic              clk, rst_n;
  logic              lval_pol, fval_pol, dval_pol;
  logic              lval, fval, dval;
  logic [NC*PW-1:0]  pix_data;
  logic              roi_en;
  logic [XW-1:0]     roi_x0, roi_w;
  logic [YW-1:0]     roi_y0, roi_h;
  logic              err_clr;
  logic              vsync, hsync, de, sof, eof, line_err;
  logic [NC*PW-1:0]  data;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [FW-1:0]     frame_cnt;

  inp_camera_roi #(
    .PIXEL_WIDTH(PW), .NUM_CH(NC), .X_WIDTH(XW), .Y_WIDTH(YW), .FCNT_WIDTH(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lval_pol(lval_pol), .fval_pol(fval_pol), .dval_pol(dval_pol),
    .lval(lval), .fval(fval), .dval(dval), .pix_data(pix_data),
    .roi_en(roi_en), .roi_x0(roi_x0), .roi_y0(roi_y0), .roi_w(roi_w), .roi_h(roi_h),
    .err_clr(err_clr),
    .vsync(vsync), .hsync(hsync), .de(de), .data(data), .x(x), .y(y),
    .sof(sof), .eof(eof), .frame_cnt(frame_cnt), .line_err(line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic [NC*PW-1:0] d;
    int               c;
  } pix_t;

  typedef struct {
    bit [2:0] pol;
    bit       en;
    int       x0, y0, w, h;
    int       l0, l1, l2;
    int       exp_de;
    bit       exp_err;
  } vec_t;

  pix_t q[$];
  pix_t mon_e;
  int   errs = 0, chks = 0;
  int   de_cnt = 0, sof_cnt = 0, eof_cnt = 0;
  bit   sof_seen = 0;
  int   exp_fcnt = 0;
  int   chg_line = -1, clr_line = -1;
  bit   chg_en;
  int   chg_x0, chg_y0, chg_w, chg_h;
  vec_t vecs[7];

  always @(negedge clk) begin
    if (rst_n) begin
      if (sof) begin sof_cnt++; sof_seen = 1; end
      if (de) begin
        de_cnt++;
        chks++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL pixel: unexpected de at cycle %0d x=%0d y=%0d", cyc, x, y);
        end else begin
          mon_e = q.pop_front();
          if (x !== mon_e.x || y !== mon_e.y || data !== mon_e.d || cyc != mon_e.c || !sof_seen) begin
            errs++;
            $display("FAIL pixel: got x=%0d y=%0d data=%h cyc=%0d sof_seen=%0b, want x=%0d y=%0d data=%h cyc=%0d",
                     x, y, data, cyc, sof_seen, mon_e.x, mon_e.y, mon_e.d, mon_e.c);
          end
        end
      end
      if (eof) begin eof_cnt++; sof_seen = 0; end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    chks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic set_pol(input bit [2:0] p);
    {dval_pol, fval_pol, lval_pol} = p;
    fval = fval_pol;
    lval = lval_pol;
    dval = dval_pol;
  endtask

  task automatic set_roi(input bit en, input int x0, input int y0, input int w, input int h);
    roi_en = en;
    roi_x0 = XW'(x0);
    roi_y0 = YW'(y0);
    roi_w  = XW'(w);
    roi_h  = YW'(h);
  endtask

  task automatic drive(input bit f, input bit l, input bit d, input logic [NC*PW-1:0] dat);
    @(negedge clk);
    fval     = f ^ fval_pol;
    lval     = l ^ lval_pol;
    dval     = d ^ dval_pol;
    pix_data = dat;
    err_clr  = 1'b0;
  endtask

  task automatic push_pix(input int col, input int ln, input bit men, input int mx0, input int my0);
    pix_t e;
    e.x = XW'(men ? col - mx0 : col);
    e.y = YW'(men ? ln - my0 : ln);
    e.d = pix_data;
    e.c = cyc + 2;
    q.push_back(e);
  endtask

  // model ROI (men..mh) is what the frame is expected to be cropped with
  task automatic run_frame(input int nl, input int l0, input int l1, input int l2,
                           input bit men, input int mx0, input int my0, input int mw, input int mh);
    int lens[3];
    lens[0] = l0; lens[1] = l1; lens[2] = l2;
    drive(0, 0, 0, '0);
    drive(1, 0, 0, '0);
    for (int ln = 0; ln < nl; ln++) begin
      if (ln == chg_line) set_roi(chg_en, chg_x0, chg_y0, chg_w, chg_h);
      for (int p = 0; p < lens[ln]; p++) begin
        if (ln == 1 && p == 1) drive(1, 1, 0, 16'hdead);
        drive(1, 1, 1, 16'($urandom));
        if (!men || (p >= mx0 && p < mx0 + mw && ln >= my0 && ln < my0 + mh))
          push_pix(p, ln, men, mx0, my0);
      end
      drive(1, 0, 0, '0);
      if (ln == clr_line) err_clr = 1'b1;
    end
    drive(0, 0, 0, '0);
    repeat (5) drive(0, 0, 0, '0);
    exp_fcnt = (exp_fcnt + 1) % (1 << FW);
  endtask

  task automatic frame_and_check(input string tag, input int nl, input int l0, input int l1, input int l2,
                                 input bit men, input int mx0, input int my0, input int mw, input int mh,
                                 input int exp_de, input bit exp_err);
    int d0, s0, e0;
    d0 = de_cnt; s0 = sof_cnt; e0 = eof_cnt;
    run_frame(nl, l0, l1, l2, men, mx0, my0, mw, mh);
    check({tag, " de_count"}, 64'(de_cnt - d0), 64'(exp_de));
    check({tag, " line_err"}, 64'(line_err), 64'(exp_err));
    check({tag, " sof_count"}, 64'(sof_cnt - s0), 64'd1);
    check({tag, " eof_count"}, 64'(eof_cnt - e0), 64'd1);
    check({tag, " frame_cnt"}, 64'(frame_cnt), 64'(exp_fcnt));
    check({tag, " queue_empty"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{3'b111, 1'b0, 0, 0, 0, 0,    4, 4, 4, 12, 1'b0};
    vecs[1] = '{3'b000, 1'b1, 1, 1, 2, 2,    4, 4, 4, 4,  1'b0};
    vecs[2] = '{3'b000, 1'b1, 0, 0, 0, 3,    4, 4, 4, 0,  1'b0};
    vecs[3] = '{3'b010, 1'b1, 3, 2, 5, 5,    4, 4, 4, 1,  1'b0};
    vecs[4] = '{3'b000, 1'b1, 2, 0, 4095, 3, 4, 4, 4, 6,  1'b0};
    vecs[5] = '{3'b101, 1'b0, 0, 0, 0, 0,    3, 3, 3, 9,  1'b0};
    vecs[6] = '{3'b000, 1'b0, 0, 0, 0, 0,    4, 4, 3, 11, 1'b1};

    rst_n    = 1'b0;
    err_clr  = 1'b0;
    pix_data = '0;
    set_pol(3'b111);
    set_roi(0, 0, 0, 0, 0);
    #12;
    check("reset_state", 64'({vsync, hsync, de, sof, eof, line_err, x, y, data, frame_cnt}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      set_pol(vecs[i].pol);
      set_roi(vecs[i].en, vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h);
      frame_and_check($sformatf("case%0d", i), 3, vecs[i].l0, vecs[i].l1, vecs[i].l2,
                      vecs[i].en, vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h,
                      vecs[i].exp_de, vecs[i].exp_err);
    end

    // sticky error: plain clear, then set and clear landing in the same cycle
    drive(0, 0, 0, '0);
    err_clr = 1'b1;
    repeat (3) drive(0, 0, 0, '0);
    check("err_clear", 64'(line_err), 64'd0);
    clr_line = 2;
    set_roi(0, 0, 0, 0, 0);
    frame_and_check("set_and_clr", 3, 4, 4, 3, 0, 0, 0, 0, 0, 11, 1'b1);
    clr_line = -1;

    // ROI rewritten mid-frame: old window this frame, new one next frame
    set_roi(1, 1, 1, 2, 2);
    chg_line = 1;
    chg_en = 1; chg_x0 = 0; chg_y0 = 0; chg_w = 3; chg_h = 1;
    frame_and_check("roi_old", 3, 4, 4, 4, 1, 1, 1, 2, 2, 4, 1'b1);
    chg_line = -1;
    frame_and_check("roi_new", 3, 4, 4, 4, 1, 0, 0, 3, 1, 3, 1'b1);

    // reset in the middle of a line
    set_roi(0, 0, 0, 0, 0);
    drive(0, 0, 0, '0);
    drive(1, 0, 0, '0);
    for (int p = 0; p < 3; p++) begin
      drive(1, 1, 1, 16'($urandom));
      push_pix(p, 0, 0, 0, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", 64'({vsync, hsync, de, sof, eof, line_err, x, y, data, frame_cnt}), 64'd0);
    q.delete();
    sof_seen = 0;
    fval = fval_pol; lval = lval_pol; dval = dval_pol;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_fcnt = 0;
    repeat (3) @(negedge clk);
    check("frame_cnt_after_reset", 64'(frame_cnt), 64'd0);
    frame_and_check("post_reset", 3, 4, 4, 4, 0, 0, 0, 0, 0, 12, 1'b0);
    for (int f = 0; f < 16; f++)
      frame_and_check($sformatf("wrap%0d", f), 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1'b0);
    check("frame_cnt_wrap", 64'(frame_cnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
